// File: rtl/tpu_pkg.sv
// Shared TPU types and constants: sequencer state encoding, host address map
// and the compute-phase length helper.
package tpu_pkg;

    typedef enum logic [1:0] {IDLE, CLEAR, COMPUTE, DONE} seq_state_t;

    localparam logic [15:0] TPU_START_ADDR = 16'h0400;
    localparam logic [15:0] C_BASE         = 16'h0300;
    localparam logic [15:0] C_LAST         = 16'h037F;

    // Cycles needed for the last A/B skew to drain through a dim x dim array
    function automatic int unsigned seq_compute_cycles(input int unsigned dim);
        return 3 * dim - 2;
    endfunction

endpackage

// File: rtl/tpu_mm_seq.sv
// Matrix-multiply sequencer: clears the C accumulators row by row, enables the
// A/B feed and systolic array for 3*DIM-2 cycles, then pulses done.
module tpu_mm_seq
    import tpu_pkg::*;
#(
    parameter int unsigned DIM = 8,
    localparam int unsigned ROWW = $clog2(DIM),
    localparam int unsigned CNTW = $clog2(3 * DIM)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stall,
    output logic            mat_en,
    output logic            clr_wr_en,
    output logic [ROWW-1:0] clr_row,
    output logic            busy,
    output logic            done,
    output logic            start_ign,
    output logic [CNTW-1:0] phase_cnt
);

    localparam logic [CNTW-1:0] LastRow     = CNTW'(DIM - 1);
    localparam logic [CNTW-1:0] LastCompute = CNTW'(seq_compute_cycles(DIM) - 1);

    seq_state_t      state_q;
    logic [CNTW-1:0] cnt_q;
    logic            stall_q;
    logic            start_ign_q;

    // stall is registered so that every output is a decode of flops only;
    // a stall sampled at one edge idles the cycle that follows it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_q     <= 1'b0;
            start_ign_q <= 1'b0;
        end else begin
            stall_q     <= stall;
            start_ign_q <= start && (state_q != IDLE);
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                    end
                end
                CLEAR: begin
                    if (!stall_q) begin
                        if (cnt_q == LastRow) begin
                            state_q <= COMPUTE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (!stall_q) begin
                        if (cnt_q == LastCompute) begin
                            state_q <= DONE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        mat_en    = (state_q == COMPUTE) && !stall_q;
        clr_wr_en = (state_q == CLEAR) && !stall_q;
        clr_row   = (state_q == CLEAR) ? cnt_q[ROWW-1:0] : '0;
        start_ign = start_ign_q;
        phase_cnt = cnt_q;
    end

endmodule

// File: tb/tb_tpu_mm_seq.sv
// Bench for tpu_mm_seq: a work-queue model of the multiply sequence checked
// every cycle, directed timing scenarios pinned by literal cycle numbers, then random traffic.
module tb_tpu_mm_seq;

    localparam int unsigned DIM  = 8;
    localparam int unsigned ROWW = $clog2(DIM);
    localparam int unsigned CNTW = $clog2(3 * DIM);

    logic            clk = 1'b0;
    logic            rst, start, stall;
    logic            mat_en, clr_wr_en, busy, done, start_ign;
    logic [ROWW-1:0] clr_row;
    logic [CNTW-1:0] phase_cnt;

    tpu_mm_seq #(.DIM(DIM)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stall     (stall),
        .mat_en    (mat_en),
        .clr_wr_en (clr_wr_en),
        .clr_row   (clr_row),
        .busy      (busy),
        .done      (done),
        .start_ign (start_ign),
        .phase_cnt (phase_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: a queue of pending work items, one per busy cycle that is not stalled.
    // kind 0 = clear row idx, 1 = compute step idx, 2 = done pulse.
    int q_kind[$];
    int q_idx[$];
    bit prev_stall;
    bit ign_now;

    int cyc;
    int done_cnt, first_done, last_done, mat_cnt, clr_cnt, busy_cnt;
    int ign_cnt, first_ign, last_ign, first_clr, first_mat;
    int ph[0:127];
    int busy_at[0:127];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input bit st, input bit sl, input bit rs);
        bit was_busy;
        if (rs) begin
            q_kind.delete();
            q_idx.delete();
            prev_stall = 1'b0;
            ign_now    = 1'b0;
            return;
        end
        was_busy = (q_kind.size() != 0);
        ign_now  = st && was_busy;
        if (was_busy && (q_kind[0] == 2 || !prev_stall)) begin
            void'(q_kind.pop_front());
            void'(q_idx.pop_front());
        end
        if (st && !was_busy) begin
            for (int r = 0; r < int'(DIM); r++) begin
                q_kind.push_back(0);
                q_idx.push_back(r);
            end
            for (int c = 0; c < 3 * int'(DIM) - 2; c++) begin
                q_kind.push_back(1);
                q_idx.push_back(c);
            end
            q_kind.push_back(2);
            q_idx.push_back(0);
        end
        prev_stall = sl;
    endtask

    task automatic reset_stats();
        cyc = 0;
        done_cnt = 0; first_done = -1; last_done = -1;
        mat_cnt = 0; clr_cnt = 0; busy_cnt = 0;
        ign_cnt = 0; first_ign = -1; last_ign = -1;
        first_clr = -1; first_mat = -1;
        for (int i = 0; i < 128; i++) begin
            ph[i] = -1;
            busy_at[i] = -1;
        end
    endtask

    // Apply inputs for the coming edge, advance one cycle, compare the new cycle.
    task automatic step(input bit st, input bit sl, input bit rs);
        int e_busy, e_done, e_mat, e_clr, e_row, e_ph, kind;
        start = st;
        stall = sl;
        rst   = rs;
        model_step(st, sl, rs);
        @(negedge clk);
        cyc++;
        e_busy = 0; e_done = 0; e_mat = 0; e_clr = 0; e_row = 0; e_ph = 0; kind = -1;
        if (q_kind.size() != 0) begin
            kind   = q_kind[0];
            e_busy = 1;
            if (kind == 2) e_done = 1;
            if (kind == 0) begin
                e_clr = !prev_stall;
                e_row = q_idx[0];
            end
            if (kind == 1) e_mat = !prev_stall;
            if (kind != 2) e_ph = q_idx[0];
        end
        chk("busy", int'(busy), e_busy);
        chk("done", int'(done), e_done);
        chk("mat_en", int'(mat_en), e_mat);
        chk("clr_wr_en", int'(clr_wr_en), e_clr);
        chk("clr_row", int'(clr_row), e_row);
        chk("start_ign", int'(start_ign), int'(ign_now));
        if (kind != 2) chk("phase_cnt", int'(phase_cnt), e_ph);
        if (e_done != 0) begin
            done_cnt++;
            if (first_done < 0) first_done = cyc;
            last_done = cyc;
        end
        if (e_mat != 0) begin
            mat_cnt++;
            if (first_mat < 0) first_mat = cyc;
        end
        if (e_clr != 0) begin
            clr_cnt++;
            if (first_clr < 0) first_clr = cyc;
        end
        if (e_busy != 0) busy_cnt++;
        if (ign_now) begin
            ign_cnt++;
            if (first_ign < 0) first_ign = cyc;
            last_ign = cyc;
        end
        if (cyc < 128) begin
            ph[cyc]      = (kind == 2) ? -1 : e_ph;
            busy_at[cyc] = e_busy;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        reset_stats();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        idle(2);

        // Plain run: start sampled at edge 0.
        reset_stats();
        step(1'b1, 1'b0, 1'b0);
        idle(40);
        chk("basic_first_clr", first_clr, 1);
        chk("basic_clr_count", clr_cnt, 8);
        chk("basic_first_mat", first_mat, 9);
        chk("basic_mat_count", mat_cnt, 22);
        chk("basic_done_cycle", first_done, 31);
        chk("basic_done_count", done_cnt, 1);
        chk("basic_busy_count", busy_cnt, 31);
        chk("basic_busy_at_32", busy_at[32], 0);

        // Stall at compute phase 4: stall sampled at edges 12..14 idles cycles 13..15.
        reset_stats();
        step(1'b1, 1'b0, 1'b0);
        for (int k = 1; k < 45; k++) step(1'b0, (k >= 12 && k <= 14), 1'b0);
        chk("stall_phase_c15", ph[15], 4);
        chk("stall_phase_c16", ph[16], 4);
        chk("stall_phase_c17", ph[17], 5);
        chk("stall_mat_count", mat_cnt, 22);
        chk("stall_done_cycle", first_done, 34);

        // Re-pulse start while busy, including during the done cycle.
        reset_stats();
        step(1'b1, 1'b0, 1'b0);
        for (int k = 1; k < 40; k++) step((k == 12 || k == 31), 1'b0, 1'b0);
        chk("ign_count", ign_cnt, 2);
        chk("ign_first", first_ign, 13);
        chk("ign_last", last_ign, 32);
        chk("ign_done_cycle", first_done, 31);
        chk("ign_done_count", done_cnt, 1);
        chk("ign_busy_at_32", busy_at[32], 0);

        // start and stall together in IDLE; stall held through edge 3.
        reset_stats();
        step(1'b1, 1'b1, 1'b0);
        for (int k = 1; k < 45; k++) step(1'b0, (k <= 3), 1'b0);
        chk("ss_busy_at_1", busy_at[1], 1);
        chk("ss_first_clr", first_clr, 5);
        chk("ss_done_cycle", first_done, 35);

        // Back-to-back sequences.
        reset_stats();
        step(1'b1, 1'b0, 1'b0);
        for (int k = 1; k < 70; k++) step((k == 32), 1'b0, 1'b0);
        chk("b2b_done_count", done_cnt, 2);
        chk("b2b_first_done", first_done, 31);
        chk("b2b_last_done", last_done, 63);
        chk("b2b_busy_at_32", busy_at[32], 0);
        chk("b2b_busy_at_33", busy_at[33], 1);

        // Reset for two cycles once phase_cnt reaches 5 in COMPUTE.
        reset_stats();
        step(1'b1, 1'b0, 1'b0);
        for (int k = 1; k < 50; k++) step(1'b0, 1'b0, (k == 14 || k == 15));
        chk("rst_phase_c14", ph[14], 5);
        chk("rst_busy_at_15", busy_at[15], 0);
        chk("rst_done_count", done_cnt, 0);

        // Random traffic.
        reset_stats();
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 299) == 0));
        end
        idle(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
